// File: rtl/ifu_fsm_ysyx_24100029_if.sv
// Instruction-fetch read channel between the IFU and instruction memory / bus.
// master: the IFU issuing requests; slave: the memory answering them.
interface ifu_fsm_ysyx_24100029_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] araddr;
   logic            arvalid;
   logic            arready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/ifu_fsm_ysyx_24100029.sv
// Multi-cycle instruction fetch and next-PC sequencer.
// Owns the architectural PC, fetches one 32-bit instruction per REQ/WAIT/ISSUE
// round over the read channel, holds it until EXU commits, then advances the PC
// from the mret/ecall/jump/branch/sequential sources. A response error or a
// WAIT timeout parks the FSM in ERR with fetch_err set until reset.
// Optional feature macro: IFU_MISALIGN_TRAP_EN -- redirects a misaligned
// jump/branch/sequential target to mtvec and pulses misalign for one cycle.
module ifu_fsm_ysyx_24100029 #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
   parameter int              TIMEOUT  = 256
) (
   input  logic                           clk,
   input  logic                           rst,
   ifu_fsm_ysyx_24100029_if.master        bus,
   output logic [31:0]                    inst,
   output logic                           inst_valid,
   input  logic                           commit,
   input  logic                           jump_flag,
   input  logic [XLEN-1:0]                jump_target,
   input  logic                           branch_flag,
   input  logic                           br_taken,
   input  logic [XLEN-1:0]                imm,
   input  logic                           ecall_flag,
   input  logic                           mret_flag,
   input  logic [XLEN-1:0]                mtvec,
   input  logic [XLEN-1:0]                mepc,
   output logic [XLEN-1:0]                pc,
   output logic [XLEN-1:0]                snpc,
   output logic [XLEN-1:0]                dnpc,
   output logic                           fetch_err,
   output logic                           misalign
);

   localparam logic [1:0] ST_REQ   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;

   // Counter only needs to reach TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]       state_reg, state_next;
   logic [XLEN-1:0]  pc_reg, pc_next;
   logic [31:0]      inst_reg, inst_next;
   logic             err_reg, err_next;
   logic             mis_reg, mis_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic             timeout_hit;
   logic [XLEN-1:0]  snpc_w;
   logic [XLEN-1:0]  br_target_w;
   logic [XLEN-1:0]  dnpc_w;
   logic [XLEN-1:0]  commit_pc_w;
   logic             commit_mis_w;

   // Timeout comparator exists only when a limit is configured.
   generate
      if (TIMEOUT != 0) begin : g_timeout
         assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // Sequential and branch targets; both wrap modulo 2^XLEN.
   assign snpc_w      = pc_reg + XLEN'(4);
   assign br_target_w = pc_reg + imm;

   // Next-PC selection in fixed priority: mret, ecall, jump, taken branch, sequential.
   always_comb begin
      dnpc_w = snpc_w;
      if (mret_flag) begin
         dnpc_w = mepc;
      end else if (ecall_flag) begin
         dnpc_w = mtvec;
      end else if (jump_flag) begin
         dnpc_w = jump_target;
      end else if (branch_flag && br_taken) begin
         dnpc_w = br_target_w;
      end
   end

`ifdef IFU_MISALIGN_TRAP_EN
   logic trap_src_w;
   logic dnpc_misaligned_w;

   // mret/ecall targets come from CSRs and are trusted, so they skip the check.
   assign trap_src_w        = mret_flag | ecall_flag;
   assign dnpc_misaligned_w = (dnpc_w[1:0] != 2'b00) && !trap_src_w;
   assign commit_pc_w       = dnpc_misaligned_w ? mtvec : dnpc_w;
   assign commit_mis_w      = dnpc_misaligned_w;
`else
   assign commit_pc_w  = dnpc_w;
   assign commit_mis_w = 1'b0;
`endif

   // FSM next-state and datapath updates.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      inst_next  = inst_reg;
      err_next   = err_reg;
      mis_next   = 1'b0;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_REQ: begin
            if (bus.arready) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_next = cnt_reg + CNT_W'(1);
            // A good response in the last allowed cycle still wins over the timeout.
            if (bus.rvalid && (bus.rresp == 2'b00)) begin
               inst_next  = bus.rdata;
               state_next = ST_ISSUE;
            end else if (bus.rvalid || timeout_hit) begin
               err_next   = 1'b1;
               state_next = ST_ERR;
            end
         end
         ST_ISSUE: begin
            if (commit) begin
               pc_next    = commit_pc_w;
               mis_next   = commit_mis_w;
               cnt_next   = '0;
               state_next = ST_REQ;
            end
         end
         ST_ERR: begin
            state_next = ST_ERR;
         end
         default: begin
            state_next = ST_ERR;
         end
      endcase
   end

   // State registers with synchronous reset overriding every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_REQ;
         pc_reg    <= RESET_PC;
         inst_reg  <= '0;
         err_reg   <= 1'b0;
         mis_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         inst_reg  <= inst_next;
         err_reg   <= err_next;
         mis_reg   <= mis_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Handshake outputs are one-hot by state, so they are never high together.
   assign bus.araddr  = pc_reg;
   assign bus.arvalid = (state_reg == ST_REQ);
   assign bus.rready  = (state_reg == ST_WAIT);
   assign inst_valid  = (state_reg == ST_ISSUE);

   assign inst      = inst_reg;
   assign pc        = pc_reg;
   assign snpc      = snpc_w;
   assign dnpc      = dnpc_w;
   assign fetch_err = err_reg;
   assign misalign  = mis_reg;

endmodule

// File: tb/tb_ifu_fsm_ysyx_24100029.sv
// Directed bench for ifu_fsm_ysyx_24100029: a scoreboard queue holds the fetch
// address expected after each commit and is popped when the DUT raises arvalid.
// A second instance with TIMEOUT=4 covers the WAIT timeout.
module tb_ifu_fsm_ysyx_24100029;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit, jump_flag, branch_flag, br_taken, ecall_flag, mret_flag;
   logic [31:0] jump_target, imm, mtvec, mepc;
   logic [31:0] inst, pc, snpc, dnpc;
   logic        inst_valid, fetch_err, misalign;
   logic [31:0] inst2, pc2, snpc2, dnpc2;
   logic        inst_valid2, fetch_err2, misalign2;

   int total  = 0;
   int passed = 0;
   int failed = 0;
   int cyc    = 0;
   logic [31:0] sb_q[$];
   int          fs_q[$];
   logic [31:0] exp_pc;
   logic        exp_mis;

   ifu_fsm_ysyx_24100029_if #(.XLEN(32)) bus ();
   ifu_fsm_ysyx_24100029_if #(.XLEN(32)) bus2 ();

   ifu_fsm_ysyx_24100029 #(.XLEN(32), .RESET_PC(32'h8000_0000), .TIMEOUT(256)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .inst(inst), .inst_valid(inst_valid), .commit(commit),
      .jump_flag(jump_flag), .jump_target(jump_target),
      .branch_flag(branch_flag), .br_taken(br_taken), .imm(imm),
      .ecall_flag(ecall_flag), .mret_flag(mret_flag), .mtvec(mtvec), .mepc(mepc),
      .pc(pc), .snpc(snpc), .dnpc(dnpc), .fetch_err(fetch_err), .misalign(misalign)
   );

   ifu_fsm_ysyx_24100029 #(.XLEN(32), .RESET_PC(32'h8000_0000), .TIMEOUT(4)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2),
      .inst(inst2), .inst_valid(inst_valid2), .commit(commit),
      .jump_flag(jump_flag), .jump_target(jump_target),
      .branch_flag(branch_flag), .br_taken(br_taken), .imm(imm),
      .ecall_flag(ecall_flag), .mret_flag(mret_flag), .mtvec(mtvec), .mepc(mepc),
      .pc(pc2), .snpc(snpc2), .dnpc(dnpc2), .fetch_err(fetch_err2), .misalign(misalign2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while the DUT should be in REQ; plays the memory side.
   task automatic do_fetch(input int ar_wait, input int r_wait,
                           input logic [31:0] data, input logic [1:0] resp);
      logic [31:0] exp_addr;
      exp_addr = 32'hxxxx_xxxx;
      if (sb_q.size() != 0) exp_addr = sb_q.pop_front();
      fs_q.push_back(cyc);
      chk("req_arvalid", bus.arvalid, 1);
      chk("req_araddr", bus.araddr, exp_addr);
      for (int i = 0; i < ar_wait; i++) begin
         @(negedge clk);
         chk("hold_araddr", bus.araddr, exp_addr);
         chk("hold_arvalid", bus.arvalid, 1);
      end
      bus.arready = 1'b1;
      @(negedge clk);
      bus.arready = 1'b0;
      chk("wait_rready", bus.rready, 1);
      chk("wait_arvalid", bus.arvalid, 0);
      for (int i = 0; i < r_wait; i++) @(negedge clk);
      bus.rdata  = data;
      bus.rresp  = resp;
      bus.rvalid = 1'b1;
      @(negedge clk);
      bus.rvalid = 1'b0;
      bus.rresp  = 2'b00;
      if (resp == 2'b00) begin
         chk("issue_valid", inst_valid, 1);
         chk("inst", inst, data);
      end
      $display("fetch addr=%h data=%h resp=%0d inst=%h err=%0b", exp_addr, data, resp, inst, fetch_err);
   endtask

   // Called at a negedge in ISSUE; drives commit with the given next-PC inputs.
   task automatic do_commit(input logic jf, input logic [31:0] jt, input logic bf,
                            input logic bt, input logic [31:0] im, input logic ef,
                            input logic mf, input logic [31:0] exp_dnpc,
                            input logic [31:0] exp_next);
      chk("commit_inst_valid", inst_valid, 1);
      jump_flag = jf; jump_target = jt; branch_flag = bf; br_taken = bt;
      imm = im; ecall_flag = ef; mret_flag = mf; commit = 1'b1;
      #1;
      chk("dnpc", dnpc, exp_dnpc);
      sb_q.push_back(exp_next);
      @(negedge clk);
      commit = 1'b0; jump_flag = 1'b0; branch_flag = 1'b0; br_taken = 1'b0;
      ecall_flag = 1'b0; mret_flag = 1'b0;
      chk("pc_after_commit", pc, exp_next);
      $display("commit dnpc=%h pc=%h misalign=%0b", exp_dnpc, pc, misalign);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; commit = 1'b0; jump_flag = 1'b0; branch_flag = 1'b0; br_taken = 1'b0;
      ecall_flag = 1'b0; mret_flag = 1'b0; jump_target = '0; imm = '0;
      mtvec = 32'h8000_0100; mepc = 32'h8000_0014;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
      bus2.arready = 1'b1; bus2.rvalid = 1'b0; bus2.rdata = '0; bus2.rresp = 2'b00;
`ifdef IFU_MISALIGN_TRAP_EN
      exp_mis = 1'b1;
`else
      exp_mis = 1'b0;
`endif

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_pc", pc, 32'h8000_0000);
      chk("rst_inst", inst, 0);
      chk("rst_fetch_err", fetch_err, 0);
      chk("rst_misalign", misalign, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_rready", bus.rready, 0);
      rst = 1'b0;
      chk("first_arvalid", bus.arvalid, 1);

      // Timeout instance: WAIT entered on the first edge after release.
      @(negedge clk);
      chk("to_wait_rready", bus2.rready, 1);
      repeat (3) @(negedge clk);
      chk("to_not_yet", fetch_err2, 0);
      @(negedge clk);
      chk("to_fetch_err", fetch_err2, 1);
      chk("to_err_arvalid", bus2.arvalid, 0);
      chk("to_err_rready", bus2.rready, 0);
      $display("timeout fetch_err2=%0b", fetch_err2);

      // Sequential fetch with zero-wait memory.
      sb_q.push_back(32'h8000_0000);
      do_fetch(0, 0, 32'h0000_0013, 2'b00);
      do_commit(0, 0, 0, 0, 0, 0, 0, 32'h8000_0004, 32'h8000_0004);
      do_fetch(0, 0, 32'h0010_0093, 2'b00);
      do_commit(0, 0, 0, 0, 0, 0, 0, 32'h8000_0008, 32'h8000_0008);
      do_fetch(0, 0, 32'h0020_0113, 2'b00);
      chk("cpi_0", fs_q[1] - fs_q[0], 3);
      chk("cpi_1", fs_q[2] - fs_q[1], 3);

      // Taken and not-taken branch from 8000_0010.
      do_commit(1, 32'h8000_0010, 0, 0, 0, 0, 0, 32'h8000_0010, 32'h8000_0010);
      do_fetch(0, 0, 32'h0000_0063, 2'b00);
      do_commit(0, 0, 1, 1, 32'hFFFF_FFF0, 0, 0, 32'h8000_0000, 32'h8000_0000);
      do_fetch(0, 0, 32'h0000_0013, 2'b00);
      do_commit(1, 32'h8000_0010, 0, 0, 0, 0, 0, 32'h8000_0010, 32'h8000_0010);
      do_fetch(0, 0, 32'h0000_0063, 2'b00);
      do_commit(0, 0, 1, 0, 32'hFFFF_FFF0, 0, 0, 32'h8000_0014, 32'h8000_0014);
      do_fetch(0, 0, 32'h0000_0073, 2'b00);

      // ecall beats jump, mret beats everything.
      do_commit(1, 32'h8000_0200, 0, 0, 0, 1, 0, 32'h8000_0100, 32'h8000_0100);
      do_fetch(0, 0, 32'h3020_0073, 2'b00);
      do_commit(0, 0, 0, 0, 0, 0, 1, 32'h8000_0014, 32'h8000_0014);
      do_fetch(0, 0, 32'h0000_0073, 2'b00);
      do_commit(1, 32'h8000_0200, 1, 1, 32'h40, 1, 1, 32'h8000_0014, 32'h8000_0014);
      do_fetch(0, 0, 32'h0000_0013, 2'b00);

      // Wrap-around of the sequential PC.
      do_commit(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      do_fetch(0, 0, 32'h0000_0013, 2'b00);
      #1;
      chk("snpc_wrap", snpc, 32'h0000_0000);
      do_commit(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000);
      do_fetch(0, 0, 32'h0000_0013, 2'b00);

      // Slow memory: arready late, rvalid later.
      do_commit(1, 32'h8000_0020, 0, 0, 0, 0, 0, 32'h8000_0020, 32'h8000_0020);
      do_fetch(5, 7, 32'hDEAD_BEEF, 2'b00);
      do_commit(0, 0, 0, 0, 0, 0, 0, 32'h8000_0024, 32'h8000_0024);

      // commit and rvalid outside their states are ignored.
      commit = 1'b1; jump_flag = 1'b1; jump_target = 32'h8000_0300;
      bus.rvalid = 1'b1; bus.rdata = 32'h1111_1111;
      @(negedge clk);
      commit = 1'b0; jump_flag = 1'b0; bus.rvalid = 1'b0;
      chk("ignore_commit_pc", pc, 32'h8000_0024);
      chk("ignore_rvalid_inst", inst, 32'hDEAD_BEEF);
      do_fetch(0, 0, 32'h0000_0013, 2'b00);

      // Misaligned jump target.
      exp_pc = exp_mis ? 32'h8000_0100 : 32'h8000_0002;
      do_commit(1, 32'h8000_0002, 0, 0, 0, 0, 0, 32'h8000_0002, exp_pc);
      chk("misalign_pulse", misalign, exp_mis);
      @(negedge clk);
      chk("misalign_clear", misalign, 0);
      do_fetch(0, 0, 32'h0000_0013, 2'b00);

      // Error response parks the FSM in ERR.
      do_commit(0, 0, 0, 0, 0, 0, 0, exp_pc + 32'd4, exp_pc + 32'd4);
      do_fetch(0, 2, 32'h0000_0000, 2'b10);
      chk("err_fetch_err", fetch_err, 1);
      bus.arready = 1'b1; bus.rvalid = 1'b1; commit = 1'b1;
      repeat (3) @(negedge clk);
      bus.arready = 1'b0; bus.rvalid = 1'b0; commit = 1'b0;
      chk("err_sticky", fetch_err, 1);
      chk("err_arvalid", bus.arvalid, 0);
      chk("err_rready", bus.rready, 0);
      chk("err_inst_valid", inst_valid, 0);
      chk("err_pc", pc, exp_pc + 32'd4);

      // Reset pulse recovers both instances.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_pc", pc, 32'h8000_0000);
      chk("rst2_fetch_err", fetch_err, 0);
      chk("rst2_inst", inst, 0);
      chk("rst2_fetch_err2", fetch_err2, 0);
      sb_q.push_back(32'h8000_0000);
      do_fetch(0, 0, 32'h0000_0013, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
